// File: rtl/seq_det_sched_pkg.sv
// Shared types and constants for the time-shared "1001" sequence detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1001;

endpackage

// File: rtl/seq_det_sched_if.sv
// Lane request/data/grant bundle plus detector results; match_cnt exists only
// when SEQ_DET_CNT_EN is defined.
interface seq_det_sched_if #(
    parameter int NLANES = 4,
    parameter int LW     = $clog2(NLANES)
);
    logic [NLANES-1:0]   req;
    logic [NLANES-1:0]   in;
    logic [NLANES-1:0]   gnt;
    logic                match;
    logic [LW-1:0]       match_lane;
    logic                busy;
`ifdef SEQ_DET_CNT_EN
    logic [NLANES*8-1:0] match_cnt;
`endif

    modport master (
        output req,
        output in,
        input  gnt,
        input  match,
        input  match_lane,
`ifdef SEQ_DET_CNT_EN
        input  match_cnt,
`endif
        input  busy
    );

    modport slave (
        input  req,
        input  in,
        output gnt,
        output match,
        output match_lane,
`ifdef SEQ_DET_CNT_EN
        output match_cnt,
`endif
        output busy
    );
endinterface

// File: rtl/seq_det_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search begins at ptr, first requester wins.
module rr_arbiter
    import seq_det_pkg::*;
#(
    parameter int NLANES = 4,
    parameter int LW     = $clog2(NLANES)
) (
    input  logic [NLANES-1:0] req,
    input  logic [LW-1:0]     ptr,
    output logic [NLANES-1:0] gnt,
    output logic [LW-1:0]     winner
);

    always_comb begin
        int unsigned idx;
        logic        found;
        logic [LW-1:0] sel;
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NLANES; i++) begin
            // Explicit wrap keeps non-power-of-two lane counts in range.
            idx = int'(ptr) + i;
            if (idx >= NLANES) idx = idx - NLANES;
            sel = LW'(idx);
            if (!found && req[sel]) begin
                found      = 1'b1;
                gnt[sel]   = 1'b1;
                winner     = sel;
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// One shared Mealy "1001" detector time-shared across NLANES lanes, with a
// 2-bit context per lane. Define SEQ_DET_CNT_EN to add per-lane match counters.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NLANES = 4,
    parameter int LW     = $clog2(NLANES)
) (
    input  logic               clk,
    input  logic               rst,
    seq_det_sched_if.slave     bus
);

    state_t            ctx [NLANES];
    logic [LW-1:0]     ptr;
    logic [NLANES-1:0] arb_gnt;
    logic [LW-1:0]     winner;
    logic              any_gnt;
    state_t            cur;
    state_t            nxt;
    logic              det;
    logic              bit_in;
    logic              match_r;
    logic [LW-1:0]     match_lane_r;

    rr_arbiter #(
        .NLANES (NLANES),
        .LW     (LW)
    ) u_arb (
        .req    (bus.req),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    assign bus.gnt = rst ? '0 : arb_gnt;
    assign any_gnt = |bus.gnt;
    assign cur     = ctx[winner];
    assign bit_in  = bus.in[winner];

    // Single shared next-state function applied to the granted lane's context.
    always_comb begin
        nxt = cur;
        det = 1'b0;
        case (cur)
            S0: nxt = (bit_in == PATTERN[3]) ? S1 : S0;
            S1: nxt = (bit_in == PATTERN[2]) ? S2 : S1;
            S2: nxt = (bit_in == PATTERN[1]) ? S3 : S1;
            S3: begin
                nxt = (bit_in == PATTERN[0]) ? S1 : S0;
                det = (bit_in == PATTERN[0]);
            end
            default: nxt = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NLANES; i++) ctx[i] <= S0;
            ptr          <= '0;
            match_r      <= 1'b0;
            match_lane_r <= '0;
        end else begin
            match_r <= any_gnt && det;
            if (any_gnt) begin
                ctx[winner] <= nxt;
                ptr         <= (winner == LW'(NLANES - 1)) ? '0 : winner + 1'b1;
                if (det) match_lane_r <= winner;
            end
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        for (int unsigned i = 0; i < NLANES; i++)
            if (ctx[i] != S0) bus.busy = 1'b1;
    end

    assign bus.match      = match_r;
    assign bus.match_lane = match_lane_r;

`ifdef SEQ_DET_CNT_EN
    logic [7:0] cnt [NLANES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NLANES; i++) cnt[i] <= '0;
        end else if (any_gnt && det && cnt[winner] != 8'hFF) begin
            cnt[winner] <= cnt[winner] + 8'd1;
        end
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_cnt
        assign bus.match_cnt[g*8 +: 8] = cnt[g];
    end
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Directed bench for seq_det_sched (4 lanes); counter checks run when
// SEQ_DET_CNT_EN is defined.
module tb_seq_det_sched;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_det_sched_if #(.NLANES(4)) bus ();

    seq_det_sched #(.NLANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive inputs, check combinational grant before the edge, then step past the edge.
    task automatic cycle(input logic [3:0] r, input logic [3:0] d,
                         input logic [3:0] eg, input string tag);
        bus.req = r;
        bus.in  = d;
        #1;
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(eg));
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        cycle(4'b1111, 4'b1111, 4'b0000, "rst");
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] ov_bits;
        logic [6:0] ov_match;
        int         pulses;
        logic [3:0] fair_exp [8];
        logic [3:0] il_req [8];
        logic [3:0] il_in  [8];
        logic [3:0] il_gnt [8];

        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        bus.req = '0;
        bus.in  = '0;

        // Reset state, gnt forced low while rst is high
        cycle(4'b1111, 4'b1111, 4'b0000, "rst0");
        cycle(4'b1111, 4'b0000, 4'b0000, "rst1");
        chk("rst_match", 32'(bus.match), 32'd0);
        chk("rst_lane", 32'(bus.match_lane), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;

        // Single lane 1,0,0,1 on lane 0
        cycle(4'b0001, 4'b0001, 4'b0001, "single_b0");
        chk("single_busy", 32'(bus.busy), 32'd1);
        chk("single_m0", 32'(bus.match), 32'd0);
        cycle(4'b0001, 4'b0000, 4'b0001, "single_b1");
        chk("single_m1", 32'(bus.match), 32'd0);
        cycle(4'b0001, 4'b0000, 4'b0001, "single_b2");
        chk("single_m2", 32'(bus.match), 32'd0);
        cycle(4'b0001, 4'b0001, 4'b0001, "single_b3");
        chk("single_m3", 32'(bus.match), 32'd1);
        chk("single_lane", 32'(bus.match_lane), 32'd0);
        cycle(4'b0000, 4'b0000, 4'b0000, "single_idle");
        chk("single_pulse_end", 32'(bus.match), 32'd0);
        chk("single_busy_s1", 32'(bus.busy), 32'd1);

        // Overlap: 1,0,0,1,0,0,1 -> matches after bits 3 and 6
        do_rst();
        ov_bits  = 7'b1001001;
        ov_match = 7'b0001001;
        pulses   = 0;
        for (int i = 0; i < 7; i++) begin
            cycle(4'b0001, {3'b000, ov_bits[6-i]}, 4'b0001, "ovl");
            chk($sformatf("ovl_m%0d", i), 32'(bus.match), 32'(ov_match[6-i]));
            if (bus.match === 1'b1) pulses++;
        end
        cycle(4'b0000, 4'b0000, 4'b0000, "ovl_idle");
        if (bus.match === 1'b1) pulses++;
        chk("ovl_pulses", 32'(pulses), 32'd2);

        // Fairness: all lanes request for 8 cycles
        do_rst();
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                     4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++)
            cycle(4'b1111, 4'b0000, fair_exp[i], $sformatf("fair%0d", i));
        chk("fair_busy", 32'(bus.busy), 32'd0);

        // Interleave: lanes 1 and 2 both send 1001, alternating grants
        do_rst();
        il_req = '{4'b0110, 4'b0110, 4'b0110, 4'b0110,
                   4'b0110, 4'b0110, 4'b0110, 4'b0100};
        il_in  = '{4'b0110, 4'b0100, 4'b0000, 4'b0000,
                   4'b0000, 4'b0010, 4'b0110, 4'b0100};
        il_gnt = '{4'b0010, 4'b0100, 4'b0010, 4'b0100,
                   4'b0010, 4'b0100, 4'b0010, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            cycle(il_req[i], il_in[i], il_gnt[i], $sformatf("il%0d", i));
            chk($sformatf("il_m%0d", i), 32'(bus.match), 32'd0);
        end
        cycle(il_req[6], il_in[6], il_gnt[6], "il6");
        chk("il_m6", 32'(bus.match), 32'd1);
        chk("il_lane6", 32'(bus.match_lane), 32'd1);
        cycle(il_req[7], il_in[7], il_gnt[7], "il7");
        chk("il_m7", 32'(bus.match), 32'd1);
        chk("il_lane7", 32'(bus.match_lane), 32'd2);
        cycle(4'b0000, 4'b0000, 4'b0000, "il_idle");
        chk("il_m_end", 32'(bus.match), 32'd0);
        chk("il_lane_hold", 32'(bus.match_lane), 32'd2);

        // Reset mid-sequence: lane 3 reaches S3, rst, then 1 restarts from S0
        do_rst();
        cycle(4'b1000, 4'b1000, 4'b1000, "rm_b0");
        cycle(4'b1000, 4'b0000, 4'b1000, "rm_b1");
        cycle(4'b1000, 4'b0000, 4'b1000, "rm_b2");
        rst = 1'b1;
        cycle(4'b1000, 4'b1000, 4'b0000, "rm_rst");
        rst = 1'b0;
        chk("rm_busy_after_rst", 32'(bus.busy), 32'd0);
        cycle(4'b1000, 4'b1000, 4'b1000, "rm_b3");
        chk("rm_no_match", 32'(bus.match), 32'd0);
        chk("rm_busy", 32'(bus.busy), 32'd1);
        cycle(4'b1000, 4'b0000, 4'b1000, "rm_c1");
        cycle(4'b1000, 4'b0000, 4'b1000, "rm_c2");
        cycle(4'b1000, 4'b1000, 4'b1000, "rm_c3");
        chk("rm_restart_match", 32'(bus.match), 32'd1);
        chk("rm_restart_lane", 32'(bus.match_lane), 32'd3);

`ifdef SEQ_DET_CNT_EN
        // 260 overlapping matches on lane 0 saturate its counter at 255
        do_rst();
        chk("cnt_rst", bus.match_cnt, 32'd0);
        cycle(4'b0001, 4'b0001, 4'b0001, "cnt_h");
        for (int i = 0; i < 260; i++) begin
            cycle(4'b0001, 4'b0000, 4'b0001, "cnt_a");
            cycle(4'b0001, 4'b0000, 4'b0001, "cnt_b");
            cycle(4'b0001, 4'b0001, 4'b0001, "cnt_c");
        end
        cycle(4'b0000, 4'b0000, 4'b0000, "cnt_idle");
        chk("cnt_lane0", 32'(bus.match_cnt[7:0]), 32'd255);
        chk("cnt_others", 32'(bus.match_cnt[31:8]), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
